// File: rtl/norm_pkg.sv
// Shared widths and state encoding for the sequential left-normalizer.
package norm_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 26;
  localparam int unsigned LZ_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lzc26.sv
// Combinational leading-zero counter for the 26-bit mantissa; 26 means all-zero.
module lzc26
  import norm_pkg::*;
(
  input  logic [MAN_W-1:0] man_i,
  output logic [LZ_W-1:0]  lz_o
);

  // Scan upward so the highest set bit wins the final assignment.
  always_comb begin
    lz_o = LZ_W'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (man_i[i]) lz_o = LZ_W'(int'(MAN_W) - 1 - i);
    end
  end

endmodule

// File: rtl/normalizer_seq.sv
// Sequential left-normalizer: shifts the mantissa left until bit 25 is set,
// decrementing the exponent, bounded so the exponent never goes below zero.
// Optional macro NORM_FAST_EN: full normalization in one SHIFT cycle via a
// 26-bit barrel shifter (STEP ignored). Default: up to STEP bits per cycle.
module normalizer_seq
  import norm_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] mantis,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic             underflow,
  output logic             zero
);

`ifdef NORM_FAST_EN
  // Whole remaining shift fits in one cycle; STEP has no effect here.
  localparam int unsigned STEP_EFF = (STEP > 0) ? MAN_W : MAN_W;
`else
  localparam int unsigned STEP_EFF = STEP;
`endif

  state_e           state_q, state_d;
  logic [EXP_W-1:0] wexp_q, wexp_d;
  logic [MAN_W-1:0] wman_q, wman_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic [MAN_W-1:0] man_out_q, man_out_d;
  logic             under_q, under_d;
  logic             zero_q, zero_d;
  logic             oval_q, oval_d;

  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] lz_ext;
  logic [EXP_W-1:0] m_amt;
  logic [EXP_W-1:0] k_amt;
  logic [MAN_W-1:0] man_sh;

  lzc26 u_lzc (
    .man_i (wman_q),
    .lz_o  (lz)
  );

  // Shift amount: limited by leading zeros, remaining exponent and per-cycle step.
  always_comb begin
    lz_ext = EXP_W'(lz);
    m_amt  = (lz_ext < wexp_q) ? lz_ext : wexp_q;
    k_amt  = (m_amt > EXP_W'(STEP_EFF)) ? EXP_W'(STEP_EFF) : m_amt;
  end

`ifdef NORM_FAST_EN
  // Full barrel shift of the working mantissa.
  always_comb begin
    man_sh = wman_q << k_amt;
  end
`else
  // Narrow shifter: only amounts 0..STEP are ever selected.
  always_comb begin
    man_sh = wman_q;
    for (int i = 1; i <= int'(STEP); i++) begin
      if (k_amt == EXP_W'(i)) man_sh = wman_q << i;
    end
  end
`endif

  // Next-state and result logic.
  always_comb begin
    state_d   = state_q;
    wexp_d    = wexp_q;
    wman_d    = wman_q;
    exp_out_d = exp_out_q;
    man_out_d = man_out_q;
    under_d   = under_q;
    zero_d    = zero_q;
    oval_d    = oval_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wexp_d  = exp;
          wman_d  = mantis;
          under_d = 1'b0;
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (wman_q == '0) begin
          exp_out_d = '0;
          man_out_d = '0;
          zero_d    = 1'b1;
          under_d   = 1'b0;
          oval_d    = 1'b1;
          state_d   = DONE;
        end else begin
          wexp_d = wexp_q - k_amt;
          wman_d = man_sh;
          if (k_amt == m_amt) begin
            exp_out_d = wexp_q - k_amt;
            man_out_d = man_sh;
            under_d   = ~man_sh[MAN_W-1];
            oval_d    = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        oval_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wexp_q    <= '0;
      wman_q    <= '0;
      exp_out_q <= '0;
      man_out_q <= '0;
      under_q   <= 1'b0;
      zero_q    <= 1'b0;
      oval_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wexp_q    <= wexp_d;
      wman_q    <= wman_d;
      exp_out_q <= exp_out_d;
      man_out_q <= man_out_d;
      under_q   <= under_d;
      zero_q    <= zero_d;
      oval_q    <= oval_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = oval_q;
  assign exp_out    = exp_out_q;
  assign mantis_out = man_out_q;
  assign underflow  = under_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_normalizer_seq.sv
// Directed bench for normalizer_seq (STEP=1, or single-cycle with NORM_FAST_EN).
module tb_normalizer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp;
  logic [25:0] mantis;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [25:0] mantis_out;
  logic        underflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  normalizer_seq #(.STEP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exp        (exp),
    .mantis     (mantis),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .mantis_out (mantis_out),
    .underflow  (underflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // Expected SHIFT-cycle count: iterative value, or 1 in single-cycle mode.
  function automatic int exp_n(input int n_iter);
`ifdef NORM_FAST_EN
    return 1;
`else
    return n_iter;
`endif
  endfunction

  // Drive one operand; return edges from accept until out_valid (capped at 100).
  task automatic send_op(input logic [7:0] e, input logic [25:0] m,
                         output int lat, output logic rdy);
    @(negedge clk);
    exp = e; mantis = m; in_valid = 1'b1;
    rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the output handshake; return in_ready/out_valid one cycle after.
  task automatic take_out(output logic rdy, output logic ov);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rdy = in_ready;
    ov  = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; exp = '0; mantis = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({out_valid, exp_out, mantis_out, underflow, zero} !== 36'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b exp=%h man=%h uf=%b z=%b rdy=%b, want all 0 rdy=1",
               out_valid, exp_out, mantis_out, underflow, zero, in_ready);
    end
  endtask

  task automatic test_normalized;
    int lat; logic r, ov;
    send_op(8'h80, 26'h2000000, lat, r);
    checks++;
    if (lat !== exp_n(1) || r !== 1'b1) begin
      errors++; $display("FAIL norm_lat: lat=%0d rdy=%b, want %0d 1", lat, r, exp_n(1));
    end
    checks++;
    if (exp_out !== 8'h80 || mantis_out !== 26'h2000000 || underflow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL norm_res: %h %h %b %b, want 80 2000000 0 0", exp_out, mantis_out, underflow, zero);
    end
    take_out(r, ov);
    checks++;
    if (r !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL norm_release: rdy=%b ov=%b, want 1 0", r, ov);
    end
  endtask

  task automatic test_lz3;
    int lat; logic r, ov;
    send_op(8'h85, 26'h0400000, lat, r);
    checks++;
    if (lat !== exp_n(3)) begin
      errors++; $display("FAIL lz3_lat: lat=%0d, want %0d", lat, exp_n(3));
    end
    checks++;
    if (exp_out !== 8'h82 || mantis_out !== 26'h2000000 || underflow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL lz3_res: %h %h %b %b, want 82 2000000 0 0", exp_out, mantis_out, underflow, zero);
    end
    take_out(r, ov);
  endtask

  task automatic test_underflow;
    int lat; logic r, ov;
    send_op(8'h02, 26'h0100000, lat, r);
    checks++;
    if (lat !== exp_n(2)) begin
      errors++; $display("FAIL uf_lat: lat=%0d, want %0d", lat, exp_n(2));
    end
    checks++;
    if (exp_out !== 8'h00 || mantis_out !== 26'h0400000 || underflow !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL uf_res: %h %h %b %b, want 00 0400000 1 0", exp_out, mantis_out, underflow, zero);
    end
    take_out(r, ov);
    send_op(8'h03, 26'h0000001, lat, r);
    checks++;
    if (lat !== exp_n(3) || exp_out !== 8'h00 || mantis_out !== 26'h0000008 || underflow !== 1'b1) begin
      errors++; $display("FAIL uf3_res: lat=%0d %h %h %b, want %0d 00 0000008 1",
                         lat, exp_out, mantis_out, underflow, exp_n(3));
    end
    take_out(r, ov);
  endtask

  task automatic test_zero;
    int lat; logic r, ov;
    send_op(8'h40, 26'h0, lat, r);
    checks++;
    if (lat !== 1 || exp_out !== 8'h00 || mantis_out !== 26'h0 || zero !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL zero_res: lat=%0d %h %h z=%b uf=%b, want 1 00 0 1 0",
                         lat, exp_out, mantis_out, zero, underflow);
    end
    take_out(r, ov);
  endtask

  task automatic test_exp_zero;
    int lat; logic r, ov;
    send_op(8'h00, 26'h0000100, lat, r);
    checks++;
    if (lat !== 1 || exp_out !== 8'h00 || mantis_out !== 26'h0000100 || underflow !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL exp0_res: lat=%0d %h %h uf=%b z=%b, want 1 00 0000100 1 0",
                         lat, exp_out, mantis_out, underflow, zero);
    end
    take_out(r, ov);
  endtask

  task automatic test_back_to_back;
    int lat; logic r, ov;
    send_op(8'h85, 26'h0400000, lat, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || exp_out !== 8'h82 || mantis_out !== 26'h2000000 ||
          underflow !== 1'b0 || zero !== 1'b0) begin
        errors++; $display("FAIL hold%0d: ov=%b rdy=%b %h %h %b %b, want 1 0 82 2000000 0 0",
                           i, out_valid, in_ready, exp_out, mantis_out, underflow, zero);
      end
    end
    take_out(r, ov);
    checks++;
    if (r !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL b2b_release: rdy=%b ov=%b, want 1 0", r, ov);
    end
    // Next operand presented in the very cycle in_ready returns.
    exp = 8'h10; mantis = 26'h1000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1 || exp_out !== 8'h0f || mantis_out !== 26'h2000000 || underflow !== 1'b0) begin
      errors++; $display("FAIL b2b_res: lat=%0d %h %h %b, want 1 0f 2000000 0",
                         lat, exp_out, mantis_out, underflow);
    end
    take_out(r, ov);
  endtask

  task automatic test_reset_mid_shift;
    int lat; logic r, ov;
    @(negedge clk);
    exp = 8'h90; mantis = 26'h0000001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
`ifndef NORM_FAST_EN
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midshift_busy: ov=%b rdy=%b, want 0 0", out_valid, in_ready);
    end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({out_valid, exp_out, mantis_out, underflow, zero} !== 36'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midshift_reset: ov=%b %h %h %b %b rdy=%b, want all 0 rdy=1",
                         out_valid, exp_out, mantis_out, underflow, zero, in_ready);
    end
    send_op(8'h90, 26'h0000001, lat, r);
    checks++;
    if (lat !== exp_n(25) || exp_out !== 8'h77 || mantis_out !== 26'h2000000 || underflow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL after_reset: lat=%0d %h %h %b %b, want %0d 77 2000000 0 0",
                         lat, exp_out, mantis_out, underflow, zero, exp_n(25));
    end
    take_out(r, ov);
  endtask

  initial begin
    test_reset;
    test_normalized;
    test_lz3;
    test_underflow;
    test_zero;
    test_exp_zero;
    test_back_to_back;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/normalizer_seq.md
# normalizer_seq

Sequential left-normalizer for the 26-bit float datapath: takes an exponent/mantissa pair and shifts the mantissa left until bit 25 is set, decrementing the exponent by the same amount. It is the inverse-direction companion of the alignment (right-shift) stage and sits after the adder, before rounding/packing. It shifts iteratively, up to STEP bits per cycle, under a valid/ready handshake on both sides, and flags zero and denormal (exponent-exhausted) results.

## Interface
- STEP, 1: maximum left-shift per cycle in iterative mode; legal values 1, 2, 4, 8.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept (high only in IDLE)
- exp  in  8  input exponent
- mantis  in  26  input mantissa, MSB = bit 25
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  downstream accepts result
- exp_out  out  8  normalized exponent
- mantis_out  out  26  normalized mantissa
- underflow  out  1  exponent reached 0 before mantissa normalized (mantissa nonzero)
- zero  out  1  input mantissa was 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: load exp/mantis into working registers, clear flags, go SHIFT.
- SHIFT, per cycle: lz = leading zeros of working mantissa (0..26); m = min(lz, working exp); k = min(STEP, m).
  - Working mantissa == 0: exp_out=0, mantis_out=0, zero=1, go DONE, no shift.
  - Otherwise shift mantissa left by k (zeros in), exp -= k. If k == m, go DONE; else stay in SHIFT.
  - On transition to DONE with nonzero mantissa: underflow = (post-shift bit 25 == 0), which holds exactly when exp reached 0.
- Input exp=0 with unnormalized nonzero mantissa: m=0, no shift, underflow=1.
- DONE: out_valid=1; exp_out/mantis_out/underflow/zero held stable. On out_ready go IDLE. No input accepted in DONE.
- Exponent never wraps: the shift is bounded by exp, so exp_out >= 0.
- Reset (rst_n low at any edge, including mid-SHIFT or DONE): state=IDLE; exp_out, mantis_out, underflow, zero, out_valid = 0; in-flight operand discarded. in_ready is decoded from state, so it is 1 after reset.

## Timing
- Input handshake completes at edge T (IDLE, in_valid=1). SHIFT occupies cycles T+1 onward.
- Number of SHIFT cycles n = max(1, ceil(m0/STEP)), where m0 = min(lz, exp) of the input.
- out_valid rises in cycle T+1+n. Already-normalized or zero input: out_valid at T+2.
- Output handshake at edge U (out_valid & out_ready): in_ready=1 in cycle U+1. Minimum initiation interval is n+2 cycles.
- All outputs are registered except in_ready, which is state-decoded with no combinational path from in_valid or out_ready.

## Configuration
- NORM_FAST_EN defined: SHIFT applies the full shift k = m in a single cycle (26-bit barrel shift), so n=1 always and STEP is ignored. Results are identical to iterative mode.
- Not defined: iterative shift as above, with a STEP-bit shifter only.

## Structure
- Package norm_pkg: EXP_W=8, MAN_W=26, LZ_W=5, and the state enum (IDLE, SHIFT, DONE).
- Sub-module lzc26: combinational 26-bit leading-zero counter. Output 0..26; 26 means zero.
- The FSM, working registers and shifter live in normalizer_seq.

## Test plan
- exp=0x80, mantis=0x2000000, STEP=1 -> exp_out=0x80, mantis_out=0x2000000, underflow=0, zero=0, out_valid at T+2.
- exp=0x85, mantis=0x0400000 (lz=3), STEP=1 -> exp_out=0x82, mantis_out=0x2000000, out_valid at T+4. With STEP=4 or NORM_FAST_EN: same result at T+2.
- exp=0x02, mantis=0x0100000 (lz=5) -> exp_out=0x00, mantis_out=0x0400000, underflow=1, zero=0.
- exp=0x40, mantis=0 -> exp_out=0, mantis_out=0, zero=1, underflow=0, out_valid at T+2.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and all outputs stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle, and a back-to-back operand is accepted.
- Drive rst_n=0 for one edge mid-SHIFT (exp=0x90, mantis=0x0000001, STEP=1) -> next cycle: IDLE, out_valid=0, all outputs 0, in_ready=1. Then a new operand normalizes correctly.
